// File: rtl/fsic_wb_axil_bridge_if.sv
// Bus bundle for the FSIC wishbone-to-AXI-Lite bridge: the mgmt-SoC wishbone
// slave port plus the AXI-Lite master port toward the configuration fabric.
// The bridge uses the slave view; the environment (mgmt core plus AXI target)
// uses the master view.
interface fsic_wb_axil_bridge_if #(
  parameter int AXI_AW = 20
);
  logic [31:0]       wbs_adr;
  logic [31:0]       wbs_wdata;
  logic [3:0]        wbs_sel;
  logic              wbs_cyc;
  logic              wbs_stb;
  logic              wbs_we;
  logic              wbs_ack;
  logic [31:0]       wbs_rdata;

  logic [AXI_AW-1:0] m_awaddr;
  logic              m_awvalid;
  logic              m_awready;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  logic [AXI_AW-1:0] m_araddr;
  logic              m_arvalid;
  logic              m_arready;
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  modport slave (
    input  wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    output wbs_ack, wbs_rdata,
    output m_awaddr, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready,
    output m_araddr, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready
  );

  modport master (
    output wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    input  wbs_ack, wbs_rdata,
    input  m_awaddr, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready,
    input  m_araddr, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready
  );
endinterface

// File: rtl/fsic_wb_axil_bridge.sv
// Wishbone-classic slave to AXI-Lite master bridge. Each wishbone hit in the
// FSIC window is replayed as exactly one AXI-Lite read or write; a response
// timeout guarantees the management core always gets its ack.
module fsic_wb_axil_bridge #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFF0_0000,
  parameter int          AXI_AW    = 20,
  parameter int          TIMEOUT   = 255
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  fsic_wb_axil_bridge_if.slave  bus,
  output logic                  err_resp,
  output logic                  err_timeout
);
  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_ACK
  } state_t;

  localparam logic [16:0] TMO_LIM = 17'(TIMEOUT);

  state_t            state_reg, state_next;
  logic [15:0]       cnt_reg;
  logic [AXI_AW-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic [3:0]        strb_reg;
  logic              aw_pend_reg, w_pend_reg;
  logic              err_resp_reg, err_timeout_reg;

  logic              hit, tmo_reached, aw_done, w_done;
  logic              fire_timeout, take_rdata, set_err_resp;

  assign hit = bus.wbs_cyc && bus.wbs_stb && ((bus.wbs_adr & ADDR_MASK) == ADDR_BASE);
  // The counter holds (cycles spent busy - 1), so this is true in the
  // TIMEOUT-th busy cycle and in every cycle after it.
  assign tmo_reached = ({1'b0, cnt_reg} + 17'd1) >= TMO_LIM;
  assign aw_done = !aw_pend_reg || bus.m_awready;
  assign w_done  = !w_pend_reg  || bus.m_wready;

  // Next-state logic; a completing handshake or response beats the timeout.
  always_comb begin
    state_next   = state_reg;
    fire_timeout = 1'b0;
    take_rdata   = 1'b0;
    set_err_resp = 1'b0;
    case (state_reg)
      S_IDLE: if (hit) state_next = bus.wbs_we ? S_WADDR : S_RADDR;
      S_WADDR: begin
        if (aw_done && w_done) state_next = S_WRESP;
        else if (tmo_reached) begin
          fire_timeout = 1'b1;
          state_next   = S_ACK;
        end
      end
      S_WRESP: begin
        if (bus.m_bvalid) begin
          set_err_resp = (bus.m_bresp != 2'b00);
          state_next   = S_ACK;
        end else if (tmo_reached) begin
          fire_timeout = 1'b1;
          state_next   = S_ACK;
        end
      end
      S_RADDR: begin
        if (bus.m_arready) state_next = S_RDATA;
        else if (tmo_reached) begin
          fire_timeout = 1'b1;
          state_next   = S_ACK;
        end
      end
      S_RDATA: begin
        if (bus.m_rvalid) begin
          take_rdata   = 1'b1;
          set_err_resp = (bus.m_rresp != 2'b00);
          state_next   = S_ACK;
        end else if (tmo_reached) begin
          fire_timeout = 1'b1;
          state_next   = S_ACK;
        end
      end
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Busy-cycle counter: held at zero in IDLE, saturating while busy.
  always_ff @(posedge wb_clk) begin
    if (wb_rst || state_reg == S_IDLE) cnt_reg <= 16'd0;
    else if (cnt_reg != 16'hFFFF)      cnt_reg <= cnt_reg + 16'd1;
  end

  // Request capture, per-channel write pending flags, read data and sticky errors.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      addr_reg        <= '0;
      wdata_reg       <= '0;
      strb_reg        <= '0;
      rdata_reg       <= '0;
      aw_pend_reg     <= 1'b0;
      w_pend_reg      <= 1'b0;
      err_resp_reg    <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      if (state_reg == S_IDLE && hit) begin
        addr_reg    <= bus.wbs_adr[AXI_AW-1:0] & ~ADDR_MASK[AXI_AW-1:0];
        wdata_reg   <= bus.wbs_wdata;
        strb_reg    <= bus.wbs_sel;
        rdata_reg   <= 32'd0;
        aw_pend_reg <= bus.wbs_we;
        w_pend_reg  <= bus.wbs_we;
      end
      if (state_reg == S_WADDR) begin
        if (bus.m_awready) aw_pend_reg <= 1'b0;
        if (bus.m_wready)  w_pend_reg  <= 1'b0;
      end
      if (take_rdata)   rdata_reg <= bus.m_rdata;
      if (fire_timeout) begin
        rdata_reg       <= 32'hFFFF_FFFF;
        err_timeout_reg <= 1'b1;
      end
      if (set_err_resp) err_resp_reg <= 1'b1;
    end
  end

  assign bus.m_awaddr  = addr_reg;
  assign bus.m_araddr  = addr_reg;
  assign bus.m_wdata   = wdata_reg;
  assign bus.m_wstrb   = strb_reg;
  assign bus.m_awvalid = (state_reg == S_WADDR) && aw_pend_reg;
  assign bus.m_wvalid  = (state_reg == S_WADDR) && w_pend_reg;
  assign bus.m_bready  = (state_reg == S_WRESP);
  assign bus.m_arvalid = (state_reg == S_RADDR);
  assign bus.m_rready  = (state_reg == S_RDATA);
  assign bus.wbs_ack   = (state_reg == S_ACK);
  assign bus.wbs_rdata = (state_reg == S_ACK) ? rdata_reg : 32'd0;
  assign err_resp      = err_resp_reg;
  assign err_timeout   = err_timeout_reg;
endmodule

// File: tb/tb_fsic_wb_axil_bridge.sv
// Bench for fsic_wb_axil_bridge: directed cases plus random traffic against
// an AXI-Lite target with per-transaction wait states. Expected ack cycle,
// data and sticky flags come from a cycle-budget model of each transaction.
module tb_fsic_wb_axil_bridge;
  localparam int          T    = 8;
  localparam logic [31:0] MASK = 32'hFFF0_0000;

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;
  logic err_resp, err_timeout;

  fsic_wb_axil_bridge_if #(.AXI_AW(20)) bus();

  fsic_wb_axil_bridge #(
    .ADDR_BASE(32'h3000_0000), .ADDR_MASK(MASK), .AXI_AW(20), .TIMEOUT(T)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .bus(bus),
    .err_resp(err_resp), .err_timeout(err_timeout)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic        we;
    logic [31:0] adr, wdata, rdata;
    logic [3:0]  sel;
    logic [1:0]  resp;
    int          da, dw, db, dar, dr;
  } req_t;

  typedef struct {
    int          ack_at;
    logic [31:0] rdata;
    logic        er, et;
  } exp_t;

  req_t req_q[$];
  exp_t exp_q[$];
  int   errors = 0, checks = 0, cyc_cnt = 0, n_acks = 0;
  logic model_er = 1'b0, model_et = 1'b0;

  always @(posedge wb_clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Transaction outcome from wait states: the address phase ends in busy
  // cycle A, the response arrives in cycle R; the bridge gives up in the
  // first cycle >= T in which the awaited event is absent.
  task automatic predict(input req_t r, output int fin, output logic to);
    int a, rr, lim;
    a = r.we ? 1 + ((r.da > r.dw) ? r.da : r.dw) : 1 + r.dar;
    if (a > T) begin
      fin = T; to = 1'b1;
    end else begin
      rr  = a + 1 + (r.we ? r.db : r.dr);
      lim = (T > a + 1) ? T : a + 1;
      if (rr <= lim) begin fin = rr;  to = 1'b0; end
      else           begin fin = lim; to = 1'b1; end
    end
  endtask

  function automatic req_t mk(input logic we, input logic [31:0] adr, input logic [31:0] d);
    req_t r;
    r.we = we; r.adr = adr; r.wdata = d; r.rdata = d; r.sel = 4'hF; r.resp = 2'b00;
    r.da = 0; r.dw = 0; r.db = 0; r.dar = 0; r.dr = 0;
    return r;
  endfunction

  // Issue one wishbone access (called at a negedge), wait for its ack and end the cycle.
  task automatic issue(input req_t r);
    int   fin;
    logic to;
    logic seen;
    exp_t e;
    predict(r, fin, to);
    if (to) model_et = 1'b1;
    else if (r.resp != 2'b00) model_er = 1'b1;
    e.ack_at = cyc_cnt + 1 + fin;
    e.rdata  = to ? 32'hFFFF_FFFF : (r.we ? 32'd0 : r.rdata);
    e.er = model_er; e.et = model_et;
    req_q.push_back(r);
    exp_q.push_back(e);
    bus.wbs_adr = r.adr; bus.wbs_wdata = r.wdata; bus.wbs_sel = r.sel; bus.wbs_we = r.we;
    bus.wbs_cyc = 1'b1; bus.wbs_stb = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge wb_clk);
      if (bus.wbs_ack) begin seen = 1'b1; break; end
    end
    chk("ack_seen", 32'(seen), 32'd1);
    bus.wbs_cyc = 1'b0; bus.wbs_stb = 1'b0;
    @(negedge wb_clk);
  endtask

  // AXI-Lite target: each ready/valid is held low for the transaction's wait count.
  initial begin
    int   aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
    req_t r;
    bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = 32'd0; bus.m_rresp = 2'b00;
    forever begin
      @(negedge wb_clk);
      if (wb_rst || req_q.size() == 0) begin
        if (!wb_rst)
          chk("axi_quiet", 32'(bus.m_awvalid | bus.m_wvalid | bus.m_bready |
                               bus.m_arvalid | bus.m_rready), 32'd0);
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_bvalid = 1'b0;
        bus.m_arready = 1'b0; bus.m_rvalid = 1'b0;
      end else begin
        r = req_q[0];
        if (r.we) chk("rd_chan_idle", 32'(bus.m_arvalid | bus.m_rready), 32'd0);
        else      chk("wr_chan_idle", 32'(bus.m_awvalid | bus.m_wvalid | bus.m_bready), 32'd0);
        bus.m_awready = 1'b0;
        if (bus.m_awvalid) begin
          bus.m_awready = (aw_c >= r.da);
          if (bus.m_awready) chk("awaddr", 32'(bus.m_awaddr), r.adr & ~MASK);
          aw_c++;
        end else aw_c = 0;
        bus.m_wready = 1'b0;
        if (bus.m_wvalid) begin
          bus.m_wready = (w_c >= r.dw);
          if (bus.m_wready) begin
            chk("wdata", bus.m_wdata, r.wdata);
            chk("wstrb", 32'(bus.m_wstrb), 32'(r.sel));
          end
          w_c++;
        end else w_c = 0;
        bus.m_bvalid = 1'b0;
        if (bus.m_bready) begin
          bus.m_bvalid = (b_c >= r.db); bus.m_bresp = r.resp; b_c++;
        end else b_c = 0;
        bus.m_arready = 1'b0;
        if (bus.m_arvalid) begin
          bus.m_arready = (ar_c >= r.dar);
          if (bus.m_arready) chk("araddr", 32'(bus.m_araddr), r.adr & ~MASK);
          ar_c++;
        end else ar_c = 0;
        bus.m_rvalid = 1'b0;
        if (bus.m_rready) begin
          bus.m_rvalid = (r_c >= r.dr); bus.m_rdata = r.rdata; bus.m_rresp = r.resp; r_c++;
        end else r_c = 0;
      end
    end
  end

  // Ack monitor: pops the scoreboard on every ack, rdata must be 0 otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge wb_clk);
      if (!wb_rst) begin
        if (bus.wbs_ack) begin
          n_acks++;
          chk("ack_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ack_cycle", cyc_cnt, e.ack_at);
            chk("ack_rdata", bus.wbs_rdata, e.rdata);
            chk("err_resp", 32'(err_resp), 32'(e.er));
            chk("err_timeout", 32'(err_timeout), 32'(e.et));
            $display("txn %0d: ack at cycle %0d rdata=0x%08h err_resp=%0d err_timeout=%0d",
                     n_acks, cyc_cnt, bus.wbs_rdata, err_resp, err_timeout);
          end
          if (req_q.size() != 0) void'(req_q.pop_front());
        end else begin
          chk("rdata_idle", bus.wbs_rdata, 32'd0);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},    32'(bus.wbs_ack), 32'd0);
    chk({tag, "_rdata"},  bus.wbs_rdata, 32'd0);
    chk({tag, "_valids"}, 32'({bus.m_awvalid, bus.m_wvalid, bus.m_bready,
                               bus.m_arvalid, bus.m_rready}), 32'd0);
    chk({tag, "_addr"},   32'(bus.m_awaddr) | 32'(bus.m_araddr), 32'd0);
    chk({tag, "_wdata"},  bus.m_wdata | 32'(bus.m_wstrb), 32'd0);
    chk({tag, "_flags"},  32'({err_resp, err_timeout}), 32'd0);
  endtask

  // Stimulus.
  initial begin
    req_t r;
    int   n0;
    logic seen;
    bus.wbs_adr = 32'd0; bus.wbs_wdata = 32'd0; bus.wbs_sel = 4'd0;
    bus.wbs_cyc = 1'b0; bus.wbs_stb = 1'b0; bus.wbs_we = 1'b0;
    repeat (3) @(negedge wb_clk);
    chk_all_zero("reset");
    wb_rst = 1'b0;
    @(negedge wb_clk);

    r = mk(1'b1, 32'h3000_0010, 32'hA5A5_1234); r.sel = 4'b0011;
    issue(r);
    r = mk(1'b0, 32'h3000_0004, 32'hCAFE_F00D); r.dr = 5;
    issue(r);
    r = mk(1'b1, 32'h3000_0100, 32'h1357_9BDF); r.da = 4;
    issue(r);
    r = mk(1'b0, 32'h3000_0008, 32'h0BAD_0BAD); r.dar = 100;
    issue(r);
    r = mk(1'b0, 32'h3000_000C, 32'h600D_DA7A); r.resp = 2'b10;
    issue(r);

    // Out-of-window access: nothing on AXI, never acked.
    n0 = n_acks;
    bus.wbs_adr = 32'h2600_0000; bus.wbs_we = 1'b0; bus.wbs_cyc = 1'b1; bus.wbs_stb = 1'b1;
    repeat (300) @(negedge wb_clk);
    bus.wbs_cyc = 1'b0; bus.wbs_stb = 1'b0;
    chk("miss_no_ack", n_acks, n0);
    @(negedge wb_clk);

    // Reset while waiting for the write response.
    r = mk(1'b1, 32'h3000_0020, 32'hDEAD_BEEF); r.db = 20;
    req_q.push_back(r);
    bus.wbs_adr = r.adr; bus.wbs_wdata = r.wdata; bus.wbs_sel = r.sel; bus.wbs_we = 1'b1;
    bus.wbs_cyc = 1'b1; bus.wbs_stb = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge wb_clk);
      if (bus.m_bready) begin seen = 1'b1; break; end
    end
    chk("wresp_reached", 32'(seen), 32'd1);
    wb_rst = 1'b1; bus.wbs_cyc = 1'b0; bus.wbs_stb = 1'b0;
    @(negedge wb_clk);
    chk_all_zero("midrst");
    req_q.delete();
    model_er = 1'b0; model_et = 1'b0;
    wb_rst = 1'b0;
    @(negedge wb_clk);
    r = mk(1'b0, 32'h3000_0040, 32'h8765_4321);
    issue(r);

    // Random traffic, occasionally stretched past the timeout.
    for (int i = 0; i < 40; i++) begin
      r = mk(1'($urandom_range(0, 1)), 32'h3000_0000 | ($urandom & 32'h000F_FFFC), $urandom);
      r.sel = 4'($urandom_range(1, 15));
      r.da = $urandom_range(0, 3); r.dw = $urandom_range(0, 3); r.db = $urandom_range(0, 3);
      r.dar = $urandom_range(0, 3); r.dr = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) r.resp = {1'b1, 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: r.da  = $urandom_range(7, 12);
          1: r.dw  = $urandom_range(7, 12);
          2: r.db  = $urandom_range(4, 9);
          3: r.dar = $urandom_range(7, 12);
          default: r.dr = $urandom_range(4, 9);
        endcase
      end
      issue(r);
    end

    repeat (3) @(negedge wb_clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fsic_wb_axil_bridge.md
# fsic_wb_axil_bridge

Wishbone-classic slave to AXI-Lite master bridge sitting directly behind the user-project wishbone port, inside the FSIC top. Accepts single mgmt-SoC transactions whose address falls in the FSIC window and replays each one as one AXI-Lite read or write toward the FSIC configuration fabric. Returns a single-cycle ack with read data. Includes a response timeout so a hung AXI target can never stall the management core.

## Interface
- ADDR_BASE, 32'h3000_0000, base of the decoded wishbone window
- ADDR_MASK, 32'hFFF0_0000, address bits compared against ADDR_BASE
- AXI_AW, 20, AXI-Lite address width; carries the offset `wbs_adr & ~ADDR_MASK`, truncated
- TIMEOUT, 255, maximum number of cycles to wait for AXI handshakes (1..65535)

Ports:
- wb_clk  in  1  single clock, rising edge
- wb_rst  in  1  synchronous, active-high reset
- wbs_adr  in  32  wishbone address
- wbs_wdata  in  32  wishbone write data
- wbs_sel  in  4  byte selects
- wbs_cyc / wbs_stb / wbs_we  in  1 each  wishbone cycle, strobe, write enable
- wbs_ack  out  1  transaction done; registered one-cycle pulse
- wbs_rdata  out  32  read data; valid only while wbs_ack=1, otherwise 0
- m_awaddr / m_awvalid / m_awready  out/out/in  AXI_AW/1/1  write address channel
- m_wdata / m_wstrb / m_wvalid / m_wready  out/out/out/in  32/4/1/1  write data channel
- m_bresp / m_bvalid / m_bready  in/in/out  2/1/1  write response channel
- m_araddr / m_arvalid / m_arready  out/out/in  AXI_AW/1/1  read address channel
- m_rdata / m_rresp / m_rvalid / m_rready  in/in/in/out  32/2/1/1  read data channel
- err_resp  out  1  sticky; set by a non-OKAY bresp/rresp
- err_timeout  out  1  sticky; set by a timeout

## Operation
- Hit: `wbs_cyc & wbs_stb & ((wbs_adr & ADDR_MASK) == ADDR_BASE)`. On a miss the bridge does nothing and never acks.
- States: IDLE, WADDR, WRESP, RADDR, RDATA, ACK.
- IDLE: a hit registers the address, write data, wstrb=wbs_sel, and the direction. Next state is WADDR if wbs_we=1, else RADDR.
- WADDR: m_awvalid and m_wvalid both assert at state entry. Each one drops independently on the edge where its ready is sampled high. Go to WRESP once both handshakes have completed, in the same cycle or in different cycles.
- WRESP: m_bready=1. When m_bvalid is sampled, go to ACK. A bresp other than 2'b00 sets err_resp.
- RADDR: m_arvalid=1 until m_arready is sampled, then go to RDATA.
- RDATA: m_rready=1. When m_rvalid is sampled, capture m_rdata and go to ACK. A rresp other than 2'b00 sets err_resp.
- ACK: wbs_ack=1 for exactly one cycle, then IDLE. wbs_rdata is the captured data on reads and 0 on writes.
- Timeout counter:
  - Clears on leaving IDLE.
  - Increments every cycle in WADDR, WRESP, RADDR or RDATA.
  - When it reaches TIMEOUT: drop all valid/ready outputs, set err_timeout, go to ACK with wbs_rdata=32'hFFFF_FFFF (reads and writes alike).
  - A late AXI response after a timeout is ignored.
- Wishbone inputs are sampled only in IDLE. Changes mid-transaction have no effect.
- Only one transaction is in flight at a time; there is no pipelining and no AXI outstanding depth above 1.

## Timing
- Reset: every output is 0, state is IDLE, counter is 0, and both sticky flags are cleared.
- wb_rst asserted mid-transaction returns to IDLE on the next edge with all valids low.
- Minimum latency, with zero-wait target:
  - Hit sampled at edge 0 → AXI valid during cycle 1.
  - Address handshake at edge 1 → bready/rready during cycle 2.
  - Response at edge 2 → wbs_ack during cycle 3.
  - Total: 3 cycles, for reads and writes.
- ACK→IDLE takes one edge. A new hit is evaluated in IDLE during the cycle after the ack. The master removes stb at the ack edge, so there is no retrigger.
- Response and timeout reaching the same edge: the response wins, with normal data and no err_timeout.
- The counter is 16 bits and saturates; no wrap is possible because TIMEOUT ≤ 65535.

## Test plan
- Write 0x3000_0010 ← 0xA5A5_1234, sel=4'b0011, zero-wait target:
  - awaddr=0x00010, wdata=0xA5A5_1234, wstrb=4'b0011.
  - Ack in cycle 3.
  - err_resp=0.
- Read 0x3000_0004, target returns 0xCAFE_F00D after 5 rvalid wait cycles → ack one cycle after rvalid, wbs_rdata=0xCAFE_F00D, and rdata=0 in all other cycles.
- Write with awready delayed 4 cycles and wready immediate → wvalid drops after 1 cycle, awvalid after 5, then bready asserts and a single ack follows.
- Target never asserts arready, TIMEOUT=8 → arvalid drops after 8 cycles, ack with rdata=0xFFFF_FFFF, err_timeout=1 held until wb_rst.
- Access to 0x2600_0000 → no AXI activity and no ack for 300 cycles. Separately, rresp=2'b10 → data acked and err_resp=1.
- wb_rst pulsed during WRESP → all outputs 0 next cycle. A following read completes normally with 3-cycle latency.
